// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch controller: stall hold, branch redirect, squash
// Redirect outputs are combinational so IF sees a branch in the cycle it resolves.
module fetch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FREEZE,
  input  logic             Q_IFID_full,
  input  logic             imem_ready,
  input  logic             branch_valid,
  input  logic [31:0]      branch_target,
  output logic             no_new_fetch,
  output logic             taken_branch1,
  output logic [31:0]      nextInstruction_address,
  output logic             fetchNull2,
  output logic [1:0]       fetch_state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             blocked;

  always_comb begin
    blocked                 = FREEZE | Q_IFID_full | ~imem_ready;
    no_new_fetch            = 1'b1;
    taken_branch1           = 1'b0;
    nextInstruction_address = 32'h0;
    fetchNull2              = 1'b0;
    state_d                 = state_q;
    pend_valid_d            = pend_valid_q;
    pend_target_d           = pend_target_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        no_new_fetch = blocked;
        if (branch_valid) begin
          taken_branch1           = 1'b1;
          nextInstruction_address = branch_target;
          if (blocked) begin
            pend_target_d = branch_target;
            pend_valid_d  = 1'b1;
            state_d       = HOLD;
          end else begin
            state_d = SQUASH;
          end
        end else begin
          state_d = blocked ? HOLD : RUN;
        end
      end
      HOLD: begin
        no_new_fetch = blocked;
        if (blocked) begin
          // Latest branch seen while stalled replaces any older pending one.
          if (branch_valid) begin
            pend_target_d = branch_target;
            pend_valid_d  = 1'b1;
          end
        end else if (branch_valid) begin
          taken_branch1           = 1'b1;
          nextInstruction_address = branch_target;
          pend_valid_d            = 1'b0;
          state_d                 = SQUASH;
        end else if (pend_valid_q) begin
          taken_branch1           = 1'b1;
          nextInstruction_address = pend_target_q;
          pend_valid_d            = 1'b0;
          state_d                 = SQUASH;
        end else begin
          state_d = RUN;
        end
      end
      SQUASH: begin
        fetchNull2   = 1'b1;
        no_new_fetch = blocked;
        if (branch_valid) begin
          if (blocked) begin
            pend_target_d = branch_target;
            pend_valid_d  = 1'b1;
            state_d       = HOLD;
          end else begin
            taken_branch1           = 1'b1;
            nextInstruction_address = branch_target;
            state_d                 = SQUASH;
          end
        end else begin
          state_d = blocked ? SQUASH : RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (no_new_fetch && (state_q != BOOT) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= BOOT;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign fetch_state = state_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FREEZE = 1'b0, Q_IFID_full = 1'b0, imem_ready = 1'b1, branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;

  logic        nnf, tb1, fn, nnf4, tb14, fn4;
  logic [31:0] addr, addr4;
  logic [1:0]  st, st4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  fetch_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .Q_IFID_full(Q_IFID_full),
    .imem_ready(imem_ready), .branch_valid(branch_valid), .branch_target(branch_target),
    .no_new_fetch(nnf), .taken_branch1(tb1), .nextInstruction_address(addr),
    .fetchNull2(fn), .fetch_state(st), .stall_cnt(cnt)
  );

  fetch_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .Q_IFID_full(Q_IFID_full),
    .imem_ready(imem_ready), .branch_valid(branch_valid), .branch_target(branch_target),
    .no_new_fetch(nnf4), .taken_branch1(tb14), .nextInstruction_address(addr4),
    .fetchNull2(fn4), .fetch_state(st4), .stall_cnt(cnt4)
  );

  typedef struct {
    logic        fz, fl, rd, bv;
    logic [31:0] bt;
    logic [1:0]  st;
    logic        nnf, tb, fn;
    logic [31:0] ad;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic fz, fl, rd, bv, input logic [31:0] bt,
                              input logic [1:0] s, input logic n, t, f,
                              input logic [31:0] a, input logic [15:0] c);
    vec_t v;
    v.fz = fz; v.fl = fl; v.rd = rd; v.bv = bv; v.bt = bt;
    v.st = s; v.nnf = n; v.tb = t; v.fn = f; v.ad = a; v.cnt = c;
    return v;
  endfunction

  function automatic logic [63:0] pk(input logic [1:0] s, input logic n, t, f,
                                     input logic [31:0] a, input logic [15:0] c,
                                     input logic [3:0] c4);
    return {7'd0, s, n, t, f, a, c, c4};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [63:0] dut_pk();
    return pk(st, nnf, tb1, fn, addr, cnt, cnt4);
  endfunction

  task automatic drive(input logic fz, fl, rd, bv, input logic [31:0] bt);
    FREEZE = fz; Q_IFID_full = fl; imem_ready = rd; branch_valid = bv; branch_target = bt;
  endtask

  // Drives a row at the current negedge, checks 1ns later, ends at next negedge.
  task automatic run_row(input string name, input vec_t v);
    logic [3:0] c4;
    drive(v.fz, v.fl, v.rd, v.bv, v.bt);
    #1;
    c4 = (v.cnt > 16'd15) ? 4'hF : v.cnt[3:0];
    chk(name, dut_pk(), pk(v.st, v.nnf, v.tb, v.fn, v.ad, v.cnt, c4));
    @(negedge CLK);
  endtask

  // Asserts reset wherever time currently is; releases it at a negedge.
  task automatic do_reset(input logic bv_during);
    RESET = 1'b0;
    drive(1'b0, 1'b0, 1'b1, bv_during, 32'hDEAD_BEEF);
    #1;
    chk("reset_outputs", dut_pk(), pk(2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 4'h0));
    @(negedge CLK);
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    RESET = 1'b1;
  endtask

  // Reference model: abstract mode plus a one-deep "latest wins" branch mailbox.
  int          m_mode;
  logic [31:0] m_mail[$];
  int          m_c16, m_c4;

  task automatic model_step(input logic fz, fl, rd, bv, input logic [31:0] bt,
                            output logic [63:0] exp);
    bit          stuck;
    bit          e_nnf, e_tb, e_fn;
    logic [31:0] e_ad;
    int          nxt;
    stuck = fz || fl || !rd;
    e_nnf = 1; e_tb = 0; e_fn = 0; e_ad = 0; nxt = m_mode;
    if (m_mode == 0) begin
      nxt = 1;
    end else begin
      e_nnf = stuck;
      e_fn  = (m_mode == 3);
      if (m_mode == 2 && !stuck && !bv && m_mail.size() != 0) begin
        e_tb = 1; e_ad = m_mail[0]; m_mail.delete(); nxt = 3;
      end else if (bv && stuck) begin
        e_tb = (m_mode == 1);
        if (e_tb) e_ad = bt;
        m_mail.delete(); m_mail.push_back(bt); nxt = 2;
      end else if (bv) begin
        e_tb = 1; e_ad = bt; m_mail.delete(); nxt = 3;
      end else if (stuck) begin
        nxt = (m_mode == 3) ? 3 : 2;
      end else begin
        nxt = 1;
      end
    end
    exp = pk(m_mode[1:0], e_nnf, e_tb, e_fn, e_ad, m_c16[15:0], m_c4[3:0]);
    if (e_nnf && m_mode != 0) begin
      if (m_c16 < 65535) m_c16++;
      if (m_c4 < 15) m_c4++;
    end
    m_mode = nxt;
  endtask

  initial begin
    logic [63:0] exp;
    logic        fz, fl, rd, bv;
    logic [31:0] bt;

    tbl.push_back(mk(0,0,1,0,32'h0,        2'd0,1,0,0,32'h0,        16'd0));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd1,0,0,0,32'h0,        16'd0));
    tbl.push_back(mk(0,0,1,1,32'h00400100, 2'd1,0,1,0,32'h00400100, 16'd0));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd3,0,0,1,32'h0,        16'd0));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd1,0,0,0,32'h0,        16'd0));
    tbl.push_back(mk(0,1,1,1,32'h100,      2'd1,1,1,0,32'h100,      16'd0));
    tbl.push_back(mk(0,1,1,1,32'h200,      2'd2,1,0,0,32'h0,        16'd1));
    tbl.push_back(mk(0,1,1,0,32'h0,        2'd2,1,0,0,32'h0,        16'd2));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd2,0,1,0,32'h200,      16'd3));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd3,0,0,1,32'h0,        16'd3));
    tbl.push_back(mk(1,0,1,1,32'h300,      2'd1,1,1,0,32'h300,      16'd3));
    tbl.push_back(mk(0,0,1,1,32'h400,      2'd2,0,1,0,32'h400,      16'd4));
    tbl.push_back(mk(0,0,0,0,32'h0,        2'd3,1,0,1,32'h0,        16'd4));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd3,0,0,1,32'h0,        16'd5));
    tbl.push_back(mk(1,1,1,0,32'h0,        2'd1,1,0,0,32'h0,        16'd5));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd2,0,0,0,32'h0,        16'd6));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd1,0,0,0,32'h0,        16'd6));
    tbl.push_back(mk(0,0,1,1,32'h500,      2'd1,0,1,0,32'h500,      16'd6));
    tbl.push_back(mk(0,0,1,1,32'h600,      2'd3,0,1,1,32'h600,      16'd6));
    tbl.push_back(mk(0,1,1,1,32'h700,      2'd3,1,0,1,32'h0,        16'd6));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd2,0,1,0,32'h700,      16'd7));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd3,0,0,1,32'h0,        16'd7));
    tbl.push_back(mk(0,0,1,0,32'h0,        2'd1,0,0,0,32'h0,        16'd7));

    #3;
    do_reset(1'b0);
    foreach (tbl[i]) run_row($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a HOLD with a pending redirect.
    run_row("hold_entry", mk(0,1,1,1,32'h800, 2'd1,1,1,0,32'h800, 16'd7));
    drive(0, 1, 1, 0, 32'h0);
    #1;
    chk("hold_pending", dut_pk(), pk(2'd2, 1'b1, 1'b0, 1'b0, 32'h0, 16'd8, 4'd8));
    #2;
    do_reset(1'b1);
    run_row("post_rst_boot", mk(0,0,1,0,32'h0, 2'd0,1,0,0,32'h0, 16'd0));
    run_row("post_rst_run",  mk(0,0,1,0,32'h0, 2'd1,0,0,0,32'h0, 16'd0));
    run_row("post_rst_run2", mk(0,0,1,0,32'h0, 2'd1,0,0,0,32'h0, 16'd0));

    // Saturation: 20 frozen cycles.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 32'h0);
      @(negedge CLK);
    end
    drive(0, 0, 1, 0, 32'h0);
    #1;
    chk("sat_cnt4", {60'd0, cnt4}, 64'd15);
    chk("sat_cnt16", {48'd0, cnt}, 64'd20);
    @(negedge CLK);

    // Randomized run against the reference model.
    do_reset(1'b0);
    m_mode = 0; m_mail.delete(); m_c16 = 0; m_c4 = 0;
    for (int i = 0; i < 3000; i++) begin
      fz = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 5) != 0);
      bv = ($urandom_range(0, 2) == 0);
      bt = $urandom;
      drive(fz, fl, rd, bv, bt);
      #1;
      model_step(fz, fl, rd, bv, bt, exp);
      chk($sformatf("rand%0d", i), dut_pk(), exp);
      @(negedge CLK);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
